// File: rtl/svfloat_ftoi.sv
// svfloat_ftoi: multi-cycle float-to-integer converter.
// The significand is aligned one bit per cycle, then rounded (RTZ or RNE),
// range-checked and signed. Valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | aligning the significand one bit per cycle
// ROUND | rounding, range check and sign application
// DONE  | result held on the outputs until out_ready

package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

module svfloat_ftoi #(
  parameter type float     = svfloat::float32,
  parameter int  int_width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  float                 in_val,
  input  logic                 in_signed,
  input  logic                 in_rne,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [int_width-1:0] out_int,
  output logic                 out_invalid,
  output logic                 out_inexact
);

  localparam int E    = $bits(in_val.exponent);
  localparam int M    = $bits(in_val.mantissa);
  localparam int W    = int_width;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int NMAX = M + 2;
  localparam int CW   = $clog2(W + NMAX + 1);

  localparam logic [W-1:0] SMAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] UMAX    = {W{1'b1}};
  localparam logic [W:0]   LIM_POS = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]   LIM_NEG = {2'b01, {(W-1){1'b0}}};
  localparam logic [W:0]   LIM_U   = {1'b0, {W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            neg_q, neg_d;
  logic            sgn_q, sgn_d;
  logic            rne_q, rne_d;
  logic            left_q, left_d;
  logic [W:0]      mag_q, mag_d;
  logic            guard_q, guard_d;
  logic            sticky_q, sticky_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;
  logic            inv_q, inv_d;
  logic            inx_q, inx_d;

  int              e_unb;
  int              n_sh;
  logic            cls_nan, cls_inf, cls_zero, cls_big, cls_left;
  logic [W-1:0]    sat_pos, sat_neg;

  logic            rnd_inc;
  logic [W:0]      rnd_mag;
  logic [W-1:0]    rnd_res;
  logic            rnd_inv, rnd_inx;

  // Classify the offered operand and work out the alignment shift.
  always_comb begin
    e_unb    = int'(in_val.exponent) - BIAS;
    cls_nan  = (&in_val.exponent) && (|in_val.mantissa);
    cls_inf  = (&in_val.exponent) && !(|in_val.mantissa);
    cls_zero = ~|in_val.exponent;
    cls_big  = e_unb >= W;
    cls_left = e_unb >= M;
    n_sh     = 0;
    if (cls_left) begin
      n_sh = e_unb - M;
    end else if ((M - e_unb) > NMAX) begin
      // Past M+2 positions only the sticky bit can change, and it is already set.
      n_sh = NMAX;
    end else begin
      n_sh = M - e_unb;
    end
    sat_pos = in_signed ? SMAX : UMAX;
    sat_neg = in_signed ? SMIN : {W{1'b0}};
  end

  // Round the aligned magnitude, check the range and apply the sign.
  always_comb begin
    rnd_inc = rne_q & guard_q & (sticky_q | mag_q[0]);
    rnd_mag = mag_q + {{W{1'b0}}, rnd_inc};
    rnd_inx = guard_q | sticky_q;
    rnd_inv = 1'b0;
    rnd_res = rnd_mag[W-1:0];
    if (sgn_q) begin
      if (neg_q) begin
        if (rnd_mag > LIM_NEG) begin
          rnd_inv = 1'b1;
          rnd_res = SMIN;
        end else begin
          rnd_res = {W{1'b0}} - rnd_mag[W-1:0];
        end
      end else if (rnd_mag > LIM_POS) begin
        rnd_inv = 1'b1;
        rnd_res = SMAX;
      end
    end else begin
      if (neg_q) begin
        // A negative value that rounds to zero is still representable.
        rnd_inv = |rnd_mag;
        rnd_res = {W{1'b0}};
      end else if (rnd_mag > LIM_U) begin
        rnd_inv = 1'b1;
        rnd_res = UMAX;
      end
    end
    if (rnd_inv) begin
      rnd_inx = 1'b0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    rne_d    = rne_q;
    left_d   = left_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    inv_d    = inv_q;
    inx_d    = inx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d    = in_val.sign;
          sgn_d    = in_signed;
          rne_d    = in_rne;
          left_d   = cls_left;
          mag_d    = {{(W-M){1'b0}}, 1'b1, in_val.mantissa};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          if (cls_nan) begin
            res_d   = sat_pos;
            inv_d   = 1'b1;
            inx_d   = 1'b0;
            state_d = DONE;
          end else if (cls_inf || (!cls_zero && cls_big)) begin
            res_d   = in_val.sign ? sat_neg : sat_pos;
            inv_d   = 1'b1;
            inx_d   = 1'b0;
            state_d = DONE;
          end else if (cls_zero) begin
            res_d   = {W{1'b0}};
            inv_d   = 1'b0;
            inx_d   = |in_val.mantissa;
            state_d = DONE;
          end else if (n_sh == 0) begin
            state_d = ROUND;
          end else begin
            // Counter holds shifts remaining after the current one.
            cnt_d   = CW'(n_sh - 1);
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[W-1:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[W:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        if (cnt_q == '0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ROUND: begin
        res_d   = rnd_res;
        inv_d   = rnd_inv;
        inx_d   = rnd_inx;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      rne_q    <= 1'b0;
      left_q   <= 1'b0;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      rne_q    <= rne_d;
      left_q   <= left_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      inv_q    <= inv_d;
      inx_q    <= inx_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_int     = res_q;
  assign out_invalid = inv_q;
  assign out_inexact = inx_q;

endmodule

// File: tb/tb_svfloat_ftoi.sv
// Bench for svfloat_ftoi: directed float32 vectors, an arithmetic reference
// model, and a scoreboard checked every cycle the result is presented.

module tb_svfloat_ftoi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        in_rne = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_val = 32'h0;
  logic        in_ready, out_valid, out_invalid, out_inexact;
  logic [31:0] out_int;

  svfloat_ftoi dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_val     (in_val),
    .in_signed  (in_signed),
    .in_rne     (in_rne),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_int    (out_int),
    .out_invalid(out_invalid),
    .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] sat(input logic neg, input logic sgn);
    if (neg) return sgn ? 32'h8000_0000 : 32'h0000_0000;
    return sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Reference: exact value = 1.m * 2^e, split into integer part and remainder.
  function automatic void model(input logic [31:0] f, input logic sgn, input logic rne,
                                output logic [31:0] r, output logic inv, output logic inx,
                                output int lat);
    logic   s;
    int     ex, e, k, n;
    longint sig, mag, rem, half;
    s   = f[31];
    ex  = int'(f[30:23]);
    r   = 32'h0;
    inv = 1'b0;
    inx = 1'b0;
    lat = 1;
    if (ex == 255) begin
      inv = 1'b1;
      r   = (f[22:0] != 0) ? sat(1'b0, sgn) : sat(s, sgn);
      return;
    end
    if (ex == 0) begin
      inx = (f[22:0] != 0);
      return;
    end
    e = ex - 127;
    if (e >= 32) begin
      inv = 1'b1;
      r   = sat(s, sgn);
      return;
    end
    sig = longint'({1'b1, f[22:0]});
    if (e >= 23) begin
      n   = e - 23;
      mag = sig << n;
    end else begin
      k    = 23 - e;
      n    = (k > 25) ? 25 : k;
      if (k > 40) k = 40;
      mag  = sig >> k;
      rem  = sig - (mag << k);
      half = longint'(1) << (k - 1);
      inx  = (rem != 0);
      if (rne && ((rem > half) || ((rem == half) && mag[0]))) mag = mag + 1;
    end
    lat = n + 2;
    if (sgn) begin
      if (s) begin
        if (mag > 64'h8000_0000) begin inv = 1'b1; r = 32'h8000_0000; end
        else r = 32'(-mag);
      end else begin
        if (mag > 64'h7FFF_FFFF) begin inv = 1'b1; r = 32'h7FFF_FFFF; end
        else r = 32'(mag);
      end
    end else begin
      if (s) begin
        inv = (mag != 0);
      end else begin
        if (mag > 64'hFFFF_FFFF) begin inv = 1'b1; r = 32'hFFFF_FFFF; end
        else r = 32'(mag);
      end
    end
    if (inv) inx = 1'b0;
  endfunction

  typedef struct {
    logic [31:0] f;
    logic        sgn;
    logic        rne;
    logic [31:0] r;
    logic        inv;
    logic        inx;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        inv;
    logic        inx;
    int          lat;
    int          n_acc;
    logic        seen;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   negcnt = 0;

  // Scoreboard: predict at each accept, compare on every cycle out_valid is high.
  always @(negedge clk) begin
    exp_t        x;
    logic [31:0] mr;
    logic        mi, mx;
    int          ml;
    negcnt++;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", {31'h0, out_valid}, 32'h0);
        end else begin
          if (!sb[0].seen) begin
            check("latency", negcnt - sb[0].n_acc, sb[0].lat);
            sb[0].seen = 1'b1;
          end
          check("out_int", out_int, sb[0].r);
          check("out_invalid", {31'h0, out_invalid}, {31'h0, sb[0].inv});
          check("out_inexact", {31'h0, out_inexact}, {31'h0, sb[0].inx});
          check("in_ready_busy", {31'h0, in_ready}, 32'h0);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model(in_val, in_signed, in_rne, mr, mi, mx, ml);
        x = '{r: mr, inv: mi, inx: mx, lat: ml, n_acc: negcnt, seen: 1'b0};
        sb.push_back(x);
      end
    end
  end

  task automatic offer(input vec_t v, input int hold);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    in_val    = v.f;
    in_signed = v.sgn;
    in_rne    = v.rne;
    in_valid  = 1'b1;
    if (hold > 0) out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_val    = $urandom;
    in_signed = 1'($urandom);
    in_rne    = 1'($urandom);
  endtask

  task automatic run(input vec_t v, input int hold);
    int w;
    offer(v, hold);
    if (hold > 0) begin
      w = 0;
      while (!out_valid && w < 60) begin @(posedge clk); #1; w++; end
      if (!out_valid) check("valid_timeout", {31'h0, out_valid}, 32'h1);
      // A second operand offered while busy must be ignored.
      in_val   = 32'h3F80_0000;
      in_valid = 1'b1;
      repeat (hold) begin @(posedge clk); #1; end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    w = 0;
    while (sb.size() != 0 && w < 80) begin @(posedge clk); #1; w++; end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'h0);
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mr;
    logic        mi, mx;
    int          ml;

    //               operand       sgn   rne   result        inv   inx
    vq.push_back('{32'h40490FDB, 1'b1, 1'b0, 32'h00000003, 1'b0, 1'b1});
    vq.push_back('{32'hC0200000, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1});
    vq.push_back('{32'hC0600000, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1});
    vq.push_back('{32'h7FC00000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0});
    vq.push_back('{32'h4F000000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0});
    vq.push_back('{32'h4F000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0});
    vq.push_back('{32'hCF000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0});
    vq.push_back('{32'hBF000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1});
    vq.push_back('{32'hBF800000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vq.push_back('{32'h3FC00000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1});
    vq.push_back('{32'h3F200000, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b1});
    vq.push_back('{32'h7F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vq.push_back('{32'hFF800000, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0});
    vq.push_back('{32'h00000001, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1});
    vq.push_back('{32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0});
    vq.push_back('{32'h4B000000, 1'b1, 1'b0, 32'h00800000, 1'b0, 1'b0});
    vq.push_back('{32'h3E800000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1});
    vq.push_back('{32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vq.push_back('{32'h4F7FFFFF, 1'b0, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0});
    vq.push_back('{32'h3F7FFFFF, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b1});
    vq.push_back('{32'hC0600000, 1'b1, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1});
    vq.push_back('{32'h40200000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1});
    vq.push_back('{32'hCF000001, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0});

    // Pin the reference model to the hand-computed table.
    foreach (vq[i]) begin
      model(vq[i].f, vq[i].sgn, vq[i].rne, mr, mi, mx, ml);
      check($sformatf("model_int[%0d]", i), mr, vq[i].r);
      check($sformatf("model_inv[%0d]", i), {31'h0, mi}, {31'h0, vq[i].inv});
      check($sformatf("model_inx[%0d]", i), {31'h0, mx}, {31'h0, vq[i].inx});
    end
    model(32'h40490FDB, 1'b1, 1'b0, mr, mi, mx, ml);
    check("model_lat_pi", ml, 24);
    model(32'h7FC00000, 1'b1, 1'b0, mr, mi, mx, ml);
    check("model_lat_nan", ml, 1);
    model(32'h3E800000, 1'b1, 1'b1, mr, mi, mx, ml);
    check("model_lat_max", ml, 27);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_int", out_int, 32'h0);
    check("rst_out_invalid", {31'h0, out_invalid}, 32'h0);
    check("rst_out_inexact", {31'h0, out_inexact}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) run(vq[i], 0);

    // Backpressure: hold the result for 10 cycles.
    run(vq[0], 10);

    // Reset while aligning, then a fresh conversion.
    offer(vq[0], 0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_out_int", out_int, 32'h0);
    run(vq[2], 0);
    run(vq[6], 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/svfloat_ftoi.md
Name: svfloat_ftoi

Overview:
- Multi-cycle floating-point to integer converter with valid/ready handshakes on both sides.
- It is the inverse-direction companion of the integer-to-float path in the svfloat library, and it feeds FCVT-style integer results back to the integer side.
- The significand is aligned with a one-bit-per-cycle shifter to keep area small.
- Supports signed or unsigned results, round-toward-zero or round-to-nearest-even, and reports invalid and inexact flags.

Parameters:
- float, svfloat::float32, floating-point type with fields sign, exponent, mantissa; E = $bits(exponent), M = $bits(mantissa), bias = 2^(E-1)-1.
- int_width, 32, width W of the integer result; must satisfy W > M+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  an operand is offered.
- in_ready  output  1  converter can accept; high only in IDLE.
- in_val  input  float  operand.
- in_signed  input  1  1 = signed result, 0 = unsigned.
- in_rne  input  1  1 = round-to-nearest-even, 0 = round-toward-zero.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_int  output  W  integer result.
- out_invalid  output  1  NaN, infinity, or out-of-range input.
- out_inexact  output  1  result differs from the exact value; never set together with out_invalid.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE; in_ready=1; out_valid=0; out_int=0; out_invalid=0; out_inexact=0.
  - Any in-flight conversion is discarded.
  - Reset has priority over every other event.
- States:
  - IDLE: accept when in_valid && in_ready. Latch sign, exponent, {hidden,mantissa}, in_signed, in_rne. Classify the operand and go to SHIFT or DONE.
  - SHIFT: shift the significand register one bit per cycle and decrement the counter. When the counter is 0 at an edge, go to ROUND.
  - ROUND: one cycle. Apply rounding, the overflow check, and sign application.
  - DONE: out_valid=1. Outputs stay stable until out_ready is high at an edge, then go to IDLE. There is no bypass: the next accept is at the earliest the cycle after the handshake.
- Classification, with e = exponent - bias:
  - NaN: go to DONE with invalid. Result is 2^(W-1)-1 if signed, all ones if unsigned, regardless of sign.
  - Infinity, or e >= W: go to DONE with invalid and the saturated value for the sign. Positive saturates to 2^(W-1)-1 (signed) or all ones (unsigned); negative saturates to -2^(W-1) (signed) or 0 (unsigned).
  - Zero or subnormal: go to DONE with result 0. Inexact = (mantissa != 0), in either rounding mode.
  - Otherwise go to SHIFT:
    - If e >= M: left shift of N = e-M.
    - If e < M: right shift of N = min(M-e, M+2).
    - If N = 0, SHIFT is skipped and the next state is ROUND.
- Right shift keeps a guard bit and a sticky bit. The sticky bit ORs every bit shifted past guard.
- Rounding:
  - RTZ truncates.
  - RNE increments the magnitude when guard && (sticky || lsb).
  - inexact = guard || sticky.
  - The magnitude register is W+1 bits wide so a rounding carry is caught.
- Range check after rounding:
  - Signed: magnitude > 2^(W-1)-1 (positive) or > 2^(W-1) (negative) gives invalid and the saturated value.
  - Unsigned: a negative input with nonzero rounded magnitude gives invalid and result 0. A negative input rounding to 0 is valid: result 0, inexact per rounding. Magnitude > 2^W-1 gives invalid and all ones.
  - When invalid, inexact is forced to 0.
- Latency from the accept edge to out_valid high:
  - 1 cycle for the DONE-direct classes.
  - Otherwise N+2 cycles.
  - Maximum for float32 is M+4 = 27.
- in_valid while busy is ignored. in_val need not be held after the accept.

Test Plan:
- 0x40490FDB (3.14159), signed, RTZ → out_int=3, inexact=1, invalid=0, out_valid 24 cycles after accept.
- 0xC0200000 (-2.5), signed, RNE → out_int=0xFFFFFFFE, inexact=1. Repeat with 0xC0600000 (-3.5) → out_int=0xFFFFFFFC.
- 0x7FC00000 (NaN), signed → 0x7FFFFFFF, invalid=1, inexact=0, latency 1.
- 0x4F000000 (2^31): signed → 0x7FFFFFFF, invalid=1; unsigned → 0x80000000, invalid=0, inexact=0.
- 0xCF000000 (-2^31), signed → 0x80000000, exact.
- Unsigned 0xBF000000 (-0.5), RNE → 0, invalid=0, inexact=1.
- Unsigned 0xBF800000 (-1.0) → 0, invalid=1, inexact=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs must stay stable and in_ready must stay 0.
- Reset mid-operation: assert rst_n=0 in SHIFT. Next cycle must show in_ready=1, out_valid=0, and a fresh conversion must be correct.
